// File: rtl/dadda_mul_arbiter.sv
// rtl/dadda_mul_arbiter.sv - round-robin arbiter sharing one pipelined multiplier among NREQ requesters
module dadda_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 16,
   parameter int MUL_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [NREQ*2*WIDTH-1:0] rsp_p,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic                    mul_en,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_p,
   output logic                    idle
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW  = 2 * WIDTH;

   logic [IDW-1:0]  rr_ptr;
   logic [NREQ-1:0] inflight;
   logic [NREQ-1:0] busy;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic            grant_any;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  idx;
   logic [IDW-1:0]  issue_id;
   logic            cap_en;
   logic [IDW-1:0]  cap_id;
   logic [MUL_LAT-1:0] tag_v;
   logic [IDW-1:0]  tag_id [MUL_LAT];

   // A requester stays busy while its operation is in flight or its result is unconsumed;
   // a result handshaking this cycle frees the requester for a same-cycle re-grant.
   assign busy      = inflight | (rsp_valid & ~rsp_ready);
   assign eligible  = req_valid & ~busy;
   assign req_ready = grant;
   assign idle      = ~|inflight & ~|rsp_valid;
   assign cap_en    = tag_v[MUL_LAT-1];
   assign cap_id    = tag_id[MUL_LAT-1];

   // Round-robin scan starting just after the last granted requester
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!grant_any && eligible[idx]) begin
            grant_any   = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
      if (!rst_n) begin
         grant     = '0;
         grant_any = 1'b0;
      end
   end

   // Register the granted operands toward the multiplier and move the priority pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_en   <= 1'b0;
         mul_a    <= '0;
         mul_b    <= '0;
         issue_id <= '0;
         rr_ptr   <= IDW'(NREQ - 1);
      end else begin
         mul_en <= grant_any;
         if (grant_any) begin
            mul_a    <= req_a[int'(grant_id)*WIDTH +: WIDTH];
            mul_b    <= req_b[int'(grant_id)*WIDTH +: WIDTH];
            issue_id <= grant_id;
            rr_ptr   <= grant_id;
         end
      end
   end

   // Shadow pipe carrying the issuing requester's id alongside the multiplier latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
      end else begin
         tag_v[0]  <= mul_en;
         tag_id[0] <= issue_id;
         for (int s = 1; s < MUL_LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // Capture returning products into the owner's result buffer and track in-flight state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight  <= '0;
         rsp_valid <= '0;
         rsp_p     <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i])
               inflight[i] <= 1'b1;
            else if (cap_en && cap_id == IDW'(i))
               inflight[i] <= 1'b0;
            if (cap_en && cap_id == IDW'(i)) begin
               rsp_valid[i]        <= 1'b1;
               rsp_p[i*PW +: PW]   <= mul_p;
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   // A returning product must never land on an unconsumed result
   always_ff @(posedge clk) begin
      if (rst_n && cap_en) assert (!rsp_valid[cap_id]);
   end
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// tb/tb_dadda_mul_arbiter.sv - randomized and directed checks of dadda_mul_arbiter against a transaction model
module tb_dadda_mul_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int NL   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   rsp_ready = '0;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;

   logic [NREQ-1:0]     rdy [NL];
   logic [NREQ-1:0]     rv  [NL];
   logic [NREQ*2*W-1:0] rp  [NL];
   logic                men [NL];
   logic [W-1:0]        ma  [NL];
   logic [W-1:0]        mb  [NL];
   logic [2*W-1:0]      mp  [NL];
   logic                idl [NL];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   function automatic int lat_of(input int l);
      return (l == 0) ? 1 : ((l == 1) ? 2 : 8);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   for (genvar l = 0; l < NL; l++) begin : lane
      localparam int LAT = (l == 0) ? 1 : ((l == 1) ? 2 : 8);
      logic [2*W-1:0] pipe [LAT];

      dadda_mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .MUL_LAT(LAT)) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(rdy[l]),
         .rsp_valid(rv[l]), .rsp_p(rp[l]), .rsp_ready(rsp_ready),
         .mul_en(men[l]), .mul_a(ma[l]), .mul_b(mb[l]), .mul_p(mp[l]),
         .idle(idl[l])
      );

      // multiplier: unsigned product delayed by LAT registers
      always @(posedge clk) begin
         pipe[0] <= 32'(ma[l]) * 32'(mb[l]);
         for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      end
      assign mp[l] = pipe[LAT-1];

      // transaction model: per requester, a countdown to its result plus the held result
      int             m_rr;
      int             m_cnt  [NREQ];
      int             m_wait [NREQ];
      logic [2*W-1:0] m_prod [NREQ];
      logic [2*W-1:0] m_rp   [NREQ];
      logic [NREQ-1:0] m_rv;
      logic           m_en;
      logic [W-1:0]   m_a;
      logic [W-1:0]   m_b;

      always @(negedge clk) begin : model
         logic [NREQ-1:0]     elig;
         logic [NREQ-1:0]     exp_rdy;
         logic [NREQ*2*W-1:0] exp_p;
         logic                exp_idle;
         int                  g;
         int                  j;
         if (!rst_n) begin
            m_rr = NREQ - 1; m_rv = '0; m_en = 1'b0; m_a = '0; m_b = '0;
            for (int i = 0; i < NREQ; i++) begin
               m_cnt[i] = 0; m_wait[i] = 0; m_rp[i] = '0; m_prod[i] = '0;
            end
            check($sformatf("L%0d reset req_ready", LAT), 64'(rdy[l]), 64'(0));
            check($sformatf("L%0d reset rsp_valid", LAT), 64'(rv[l]), 64'(0));
            check($sformatf("L%0d reset rsp_p", LAT), 64'(rp[l] != '0), 64'(0));
            check($sformatf("L%0d reset mul", LAT), 64'({men[l], ma[l], mb[l]}), 64'(0));
            check($sformatf("L%0d reset idle", LAT), 64'(idl[l]), 64'(1));
         end else begin
            g = -1;
            exp_rdy = '0;
            exp_idle = (m_rv == '0);
            for (int i = 0; i < NREQ; i++) begin
               elig[i] = req_valid[i] && (m_cnt[i] == 0) && !(m_rv[i] && !rsp_ready[i]);
               exp_p[i*2*W +: 2*W] = m_rp[i];
               if (m_cnt[i] != 0) exp_idle = 1'b0;
            end
            for (int k = 1; k <= NREQ; k++) begin
               j = (m_rr + k) % NREQ;
               if (g < 0 && elig[j]) g = j;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check($sformatf("L%0d req_ready", LAT), 64'(rdy[l]), 64'(exp_rdy));
            check($sformatf("L%0d rsp_valid", LAT), 64'(rv[l]), 64'(m_rv));
            check($sformatf("L%0d rsp_p", LAT), 64'(rp[l] == exp_p), 64'(1));
            check($sformatf("L%0d mul_en", LAT), 64'(men[l]), 64'(m_en));
            check($sformatf("L%0d mul_ab", LAT), 64'({ma[l], mb[l]}), 64'({m_a, m_b}));
            check($sformatf("L%0d idle", LAT), 64'(idl[l]), 64'(exp_idle));
            for (int i = 0; i < NREQ; i++) begin
               if (rdy[l][i] || !elig[i]) m_wait[i] = 0;
               else if (rdy[l] != '0) begin
                  m_wait[i]++;
                  check($sformatf("L%0d fairness r%0d", LAT, i), 64'(m_wait[i] <= NREQ - 1), 64'(1));
               end
            end
            // advance the model across the coming rising edge
            for (int i = 0; i < NREQ; i++) begin
               if (m_rv[i] && rsp_ready[i]) m_rv[i] = 1'b0;
               if (m_cnt[i] == 1) begin
                  m_rv[i] = 1'b1; m_rp[i] = m_prod[i]; m_cnt[i] = 0;
               end else if (m_cnt[i] > 1) m_cnt[i]--;
            end
            m_en = (g >= 0);
            if (g >= 0) begin
               m_a = req_a[g*W +: W];
               m_b = req_b[g*W +: W];
               m_prod[g] = 32'(m_a) * 32'(m_b);
               m_cnt[g] = LAT + 1;
               m_rr = g;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = '1;
      repeat (12) tick();
   endtask

   task automatic single_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp);
      set_op(r, a, b);
      req_valid = '0;
      req_valid[r] = 1'b1;
      rsp_ready = '1;
      sample();
      for (int l = 0; l < NL; l++) check("single grant", 64'(rdy[l][r]), 64'(1));
      for (int c = 1; c <= 12; c++) begin
         tick();
         req_valid = '0;
         sample();
         for (int l = 0; l < NL; l++) begin
            check($sformatf("single L%0d c%0d rsp_valid", lat_of(l), c),
                  64'(rv[l][r]), 64'(c == lat_of(l) + 2));
            if (c == lat_of(l) + 2)
               check($sformatf("single L%0d product", lat_of(l)), 64'(rp[l][r*2*W +: 2*W]), 64'(exp));
            if (c == 1) check("single mul_en", 64'(men[l]), 64'(1));
            if (c == lat_of(l) + 3) check("single idle", 64'(idl[l]), 64'(1));
         end
      end
      tick();
   endtask

   initial begin : main
      int ngr;
      int nother;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      sample();
      for (int l = 0; l < NL; l++) check("post-reset idle", 64'(idl[l]), 64'(1));
      tick();

      single_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      single_op(1, 16'h0000, 16'h1234, 32'h00000000);
      single_op(3, 16'h8000, 16'h8000, 32'h40000000);

      // all four requesters at once
      for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'h0100);
      req_valid = '1;
      rsp_ready = '1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         for (int i = 0; i < NREQ; i++) if (c > i) req_valid[i] = 1'b0;
         sample();
         check($sformatf("all4 grant c%0d", c), 64'(rdy[1]), 64'((c <= 3) ? (1 << c) : 0));
         if (c >= 4 && c <= 7) begin
            check($sformatf("all4 rsp_valid c%0d", c), 64'(rv[1]), 64'(1 << (c - 4)));
            check($sformatf("all4 product c%0d", c), 64'(rp[1][(c-4)*2*W +: 2*W]), 64'((c - 3) * 256));
         end
      end
      tick();
      drain();

      // fairness between requesters 1 and 3
      set_op(1, 16'h0011, 16'h0022);
      set_op(3, 16'h0033, 16'h0044);
      req_valid = 4'b1010;
      rsp_ready = '1;
      ngr = 0;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) tick();
         sample();
         if (rdy[1] != '0) begin
            check($sformatf("fair grant %0d", ngr), 64'(rdy[1]), 64'((ngr % 2 == 0) ? 4'b0010 : 4'b1000));
            ngr++;
         end
      end
      check("fair grant count", 64'(ngr >= 10), 64'(1));
      tick();
      drain();

      // backpressure on requester 2
      set_op(2, 16'h1234, 16'h0002);
      req_valid = 4'b0100;
      rsp_ready = 4'b1011;
      nother = 0;
      sample();
      for (int l = 0; l < NL; l++) check("bp first grant", 64'(rdy[l][2]), 64'(1));
      for (int c = 1; c <= 13; c++) begin
         tick();
         req_valid = 4'b0111;
         set_op(0, 16'($urandom), 16'($urandom));
         set_op(1, 16'($urandom), 16'($urandom));
         sample();
         for (int l = 0; l < NL; l++) check($sformatf("bp blocked c%0d", c), 64'(rdy[l][2]), 64'(0));
         if (rdy[1][1:0] != 2'b00) nother++;
         if (c >= 4) check($sformatf("bp held c%0d", c), 64'({rv[1][2], rp[1][2*2*W +: 2*W]}), {31'd0, 1'b1, 32'h00002468});
      end
      check("bp others issued", 64'(nother >= 4), 64'(1));
      tick();
      req_valid = 4'b0100;
      rsp_ready = '1;
      sample();
      for (int l = 0; l < NL; l++) check("bp regrant", 64'(rdy[l]), 64'(4'b0100));
      tick();
      drain();

      // reset while two operations are in flight
      set_op(0, 16'h0101, 16'h0202);
      set_op(1, 16'h0303, 16'h0404);
      req_valid = 4'b0011;
      sample();
      for (int l = 0; l < NL; l++) check("mid grant0", 64'(rdy[l]), 64'(4'b0001));
      tick();
      req_valid = 4'b0010;
      sample();
      for (int l = 0; l < NL; l++) check("mid grant1", 64'(rdy[l]), 64'(4'b0010));
      tick();
      rst_n = 1'b0;
      req_valid = 4'b0011;
      sample();
      for (int l = 0; l < NL; l++)
         check("mid reset outputs", 64'({rdy[l], rv[l], men[l], idl[l]}), 64'(1));
      tick();
      rst_n = 1'b1;
      req_valid = '0;
      for (int c = 3; c <= 14; c++) begin
         sample();
         for (int l = 0; l < NL; l++) check($sformatf("mid no rsp c%0d", c), 64'(rv[l]), 64'(0));
         tick();
      end
      req_valid = '1;
      sample();
      for (int l = 0; l < NL; l++) check("mid first grant", 64'(rdy[l]), 64'(4'b0001));
      tick();
      drain();

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         req_valid = NREQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0) ? '1 : NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 5))
               0:       begin va = 16'h0000; vb = 16'($urandom); end
               1:       begin va = 16'hFFFF; vb = 16'hFFFF; end
               2:       begin va = 16'h8000; vb = 16'h8000; end
               default: begin va = 16'($urandom); vb = 16'($urandom); end
            endcase
            set_op(i, va, vb);
         end
         tick();
      end
      drain();
      sample();
      for (int l = 0; l < NL; l++) check("final idle", 64'(idl[l]), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
